// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 responder speaking the ADXL362 register protocol (0x0A write, 0x0B read).
// SPI pins are oversampled with clk; all SPI activity is decoded from synchronized edges.
module adxl362_spi_responder #(
  parameter int unsigned SCLK_DIV_MIN = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk_i,
  input  logic        ncs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  input  logic [11:0] xdata_i,
  input  logic [11:0] ydata_i,
  input  logic [11:0] zdata_i,
  input  logic [11:0] temp_i,
  input  logic        data_ready_i,
  output logic [7:0]  filter_ctl_o,
  output logic [7:0]  power_ctl_o,
  output logic        wr_stb_o,
  output logic [5:0]  wr_addr_o,
  output logic [7:0]  wr_data_o
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StIgnore} state_e;

  localparam int unsigned NumCfg    = 15;
  localparam int unsigned FilterIdx = 12;
  localparam int unsigned PowerIdx  = 13;

  logic [1:0] sclk_sync_q, ncs_sync_q, mosi_sync_q;
  logic       sclk_dly_q, ncs_dly_q;
  logic       sclk_rise, sclk_fall, ncs_fall, ncs_s, mosi_s;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_q;
  logic [7:0] tx_q;
  logic [5:0] ptr_q;
  logic       is_rd_q;
  logic [11:0] snap_x_q, snap_y_q, snap_z_q, snap_t_q;
  logic        snap_rdy_q;
  logic [7:0]  cfg_q [NumCfg];

  logic [7:0] rx_byte;
  logic [5:0] rd_addr;
  logic [7:0] rd_byte;
  logic       wr_in_cfg;
  logic [3:0] wr_idx;

  // Flops reset low so a chip select already low at reset release is not seen as a
  // falling edge: the block waits for a fresh select.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '0;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ncs_dly_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk_i};
      ncs_sync_q  <= {ncs_sync_q[0], ncs_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sclk_dly_q  <= sclk_sync_q[1];
      ncs_dly_q   <= ncs_sync_q[1];
    end
  end

  assign ncs_s     = ncs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  assign rx_byte   = {rx_q, mosi_s};
  assign wr_in_cfg = (ptr_q >= 6'h20) && (ptr_q <= 6'h2E);
  assign wr_idx    = 4'(ptr_q - 6'h20);

  // Byte to present next: the freshly received address, or the one after the pointer.
  assign rd_addr = (state_q == StAddr) ? rx_byte[5:0] : ptr_q + 6'd1;

  always_comb begin
    rd_byte = 8'h00;
    unique case (rd_addr)
      6'h00: rd_byte = 8'hAD;
      6'h01: rd_byte = 8'h1D;
      6'h02: rd_byte = 8'hF2;
      6'h03: rd_byte = 8'h01;
      6'h08: rd_byte = snap_x_q[11:4];
      6'h09: rd_byte = snap_y_q[11:4];
      6'h0A: rd_byte = snap_z_q[11:4];
      6'h0B: rd_byte = {7'b0, snap_rdy_q};
      6'h0E: rd_byte = snap_x_q[7:0];
      6'h0F: rd_byte = {{4{snap_x_q[11]}}, snap_x_q[11:8]};
      6'h10: rd_byte = snap_y_q[7:0];
      6'h11: rd_byte = {{4{snap_y_q[11]}}, snap_y_q[11:8]};
      6'h12: rd_byte = snap_z_q[7:0];
      6'h13: rd_byte = {{4{snap_z_q[11]}}, snap_z_q[11:8]};
      6'h14: rd_byte = snap_t_q[7:0];
      6'h15: rd_byte = {{4{snap_t_q[11]}}, snap_t_q[11:8]};
      default: begin
        if (rd_addr >= 6'h20 && rd_addr <= 6'h2E) rd_byte = cfg_q[4'(rd_addr - 6'h20)];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      is_rd_q    <= 1'b0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      wr_stb_o   <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      snap_x_q   <= '0;
      snap_y_q   <= '0;
      snap_z_q   <= '0;
      snap_t_q   <= '0;
      snap_rdy_q <= 1'b0;
      for (int i = 0; i < NumCfg; i++) cfg_q[i] <= (i == FilterIdx) ? 8'h13 : 8'h00;
    end else begin
      wr_stb_o <= 1'b0;
      if (ncs_s) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
        miso_o    <= 1'b0;
        miso_oe_o <= 1'b0;
      end else if (state_q == StIdle) begin
        if (ncs_fall) begin
          state_q    <= StCmd;
          bit_cnt_q  <= '0;
          miso_o     <= 1'b0;
          miso_oe_o  <= 1'b1;
          snap_x_q   <= xdata_i;
          snap_y_q   <= ydata_i;
          snap_z_q   <= zdata_i;
          snap_t_q   <= temp_i;
          snap_rdy_q <= data_ready_i;
        end
      end else if (sclk_rise) begin
        rx_q      <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (state_q)
            StCmd: begin
              if (rx_byte == 8'h0A) begin
                state_q <= StAddr;
                is_rd_q <= 1'b0;
              end else if (rx_byte == 8'h0B) begin
                state_q <= StAddr;
                is_rd_q <= 1'b1;
              end else begin
                state_q <= StIgnore;
              end
            end
            StAddr: begin
              ptr_q <= rx_byte[5:0];
              if (is_rd_q) begin
                state_q <= StRdata;
                tx_q    <= rd_byte;
                miso_o  <= rd_byte[7];
              end else begin
                state_q <= StWdata;
              end
            end
            StWdata: begin
              wr_stb_o  <= 1'b1;
              wr_addr_o <= ptr_q;
              wr_data_o <= rx_byte;
              if (wr_in_cfg) cfg_q[wr_idx] <= rx_byte;
              if (ptr_q == 6'h1F && rx_byte == 8'h52) begin
                for (int i = 0; i < NumCfg; i++) cfg_q[i] <= (i == FilterIdx) ? 8'h13 : 8'h00;
              end
              ptr_q <= ptr_q + 6'd1;
            end
            StRdata: begin
              ptr_q  <= ptr_q + 6'd1;
              tx_q   <= rd_byte;
              miso_o <= rd_byte[7];
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == StRdata && bit_cnt_q != 3'd0) begin
        // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
        miso_o <= tx_q[6];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end
  end

  assign filter_ctl_o = cfg_q[FilterIdx];
  assign power_ctl_o  = cfg_q[PowerIdx];

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: a bit-banged SPI master with per-feature tasks.
module tb_adxl362_spi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk_i = 1'b0;
  logic        ncs_i = 1'b1;
  logic        mosi_i = 1'b0;
  logic        miso_o, miso_oe_o;
  logic [11:0] xdata_i = '0, ydata_i = '0, zdata_i = '0, temp_i = '0;
  logic        data_ready_i = 1'b0;
  logic [7:0]  filter_ctl_o, power_ctl_o;
  logic        wr_stb_o;
  logic [5:0]  wr_addr_o;
  logic [7:0]  wr_data_o;

  int errors = 0;
  int checks = 0;
  int stb_cnt = 0;

  adxl362_spi_responder #(.SCLK_DIV_MIN(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_i       (sclk_i),
    .ncs_i        (ncs_i),
    .mosi_i       (mosi_i),
    .miso_o       (miso_o),
    .miso_oe_o    (miso_oe_o),
    .xdata_i      (xdata_i),
    .ydata_i      (ydata_i),
    .zdata_i      (zdata_i),
    .temp_i       (temp_i),
    .data_ready_i (data_ready_i),
    .filter_ctl_o (filter_ctl_o),
    .power_ctl_o  (power_ctl_o),
    .wr_stb_o     (wr_stb_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_stb_o === 1'b1) stb_cnt++;

  // SCLK half period is 50 ns = 5 clk; all pin changes land on clk falling edges.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi_i = tx[i];
      #50 sclk_i = 1'b1;
      rx[i] = miso_o;
      #50 sclk_i = 1'b0;
    end
  endtask

  task automatic cs_low();
    ncs_i = 1'b0;
    #50;
  endtask

  task automatic cs_high();
    #50 ncs_i = 1'b1;
    #100;
  endtask

  task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
    logic [7:0] rx;
    cs_low();
    spi_xfer(8'h0A, 8, rx);
    spi_xfer({2'b00, addr}, 8, rx);
    spi_xfer(data, 8, rx);
    cs_high();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (miso_o !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso_o); end
    checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", miso_oe_o); end
    checks++; if (wr_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", wr_stb_o); end
    checks++; if (wr_addr_o !== 6'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr_o); end
    checks++; if (wr_data_o !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data_o); end
    checks++; if (filter_ctl_o !== 8'h13) begin errors++; $display("FAIL reset_filter got %h want 13", filter_ctl_o); end
    checks++; if (power_ctl_o !== 8'h00) begin errors++; $display("FAIL reset_power got %h want 00", power_ctl_o); end
  endtask

  task automatic test_id_read();
    logic [7:0] rx;
    logic [7:0] exp [4];
    exp = '{8'hAD, 8'h1D, 8'hF2, 8'h01};
    checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL id_oe_before got %b want 0", miso_oe_o); end
    cs_low();
    checks++; if (miso_oe_o !== 1'b1) begin errors++; $display("FAIL id_oe_selected got %b want 1", miso_oe_o); end
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h00, 8, rx);
    for (int i = 0; i < 4; i++) begin
      spi_xfer(8'h00, 8, rx);
      checks++;
      if (rx !== exp[i]) begin errors++; $display("FAIL id_byte%0d got %h want %h", i, rx, exp[i]); end
    end
    cs_high();
    checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL id_oe_after got %b want 0", miso_oe_o); end
  endtask

  task automatic test_write_power();
    logic [7:0] rx;
    int s0;
    s0 = stb_cnt;
    spi_write(6'h2D, 8'h02);
    checks++; if (power_ctl_o !== 8'h02) begin errors++; $display("FAIL wr_power got %h want 02", power_ctl_o); end
    checks++; if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL wr_stb_count got %0d want 1", stb_cnt - s0); end
    checks++; if (wr_addr_o !== 6'h2D) begin errors++; $display("FAIL wr_addr got %h want 2d", wr_addr_o); end
    checks++; if (wr_data_o !== 8'h02) begin errors++; $display("FAIL wr_data got %h want 02", wr_data_o); end
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'h00, 8, rx);
    cs_high();
    checks++; if (rx !== 8'h02) begin errors++; $display("FAIL readback_power got %h want 02", rx); end
  endtask

  task automatic test_snapshot();
    logic [7:0] rx;
    xdata_i = 12'h9A5;
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h0E, 8, rx);
    spi_xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL snap_xl got %h want a5", rx); end
    xdata_i = 12'h123;
    spi_xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'hF9) begin errors++; $display("FAIL snap_xh got %h want f9", rx); end
    cs_high();
  endtask

  task automatic test_samples();
    logic [7:0] rx;
    logic [7:0] exp [4];
    xdata_i = 12'h9A5; ydata_i = 12'h7F0; zdata_i = 12'h801; data_ready_i = 1'b1;
    exp = '{8'h9A, 8'h7F, 8'h80, 8'h01};
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h08, 8, rx);
    for (int i = 0; i < 4; i++) begin
      spi_xfer(8'h00, 8, rx);
      checks++;
      if (rx !== exp[i]) begin errors++; $display("FAIL sample_byte%0d got %h want %h", i, rx, exp[i]); end
    end
    cs_high();
    data_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h3F, 8, rx);
    spi_xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL wrap_3f got %h want 00", rx); end
    spi_xfer(8'h00, 8, rx);
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL wrap_00 got %h want ad", rx); end
    cs_high();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] rx;
    logic [7:0] acc;
    int s0;
    s0 = stb_cnt;
    acc = '0;
    cs_low();
    spi_xfer(8'h0D, 8, rx);
    acc |= rx;
    for (int i = 0; i < 3; i++) begin
      spi_xfer(8'h2D, 8, rx);
      acc |= rx;
    end
    cs_high();
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL badcmd_miso got %h want 00", acc); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL badcmd_stb got %0d want 0", stb_cnt - s0); end
    checks++; if (power_ctl_o !== 8'h02) begin errors++; $display("FAIL badcmd_power got %h want 02", power_ctl_o); end
  endtask

  task automatic test_soft_reset();
    logic [7:0] rx;
    int s0;
    spi_write(6'h2C, 8'h55);
    checks++; if (filter_ctl_o !== 8'h55) begin errors++; $display("FAIL sr_filter_wr got %h want 55", filter_ctl_o); end
    spi_write(6'h1F, 8'h52);
    checks++; if (filter_ctl_o !== 8'h13) begin errors++; $display("FAIL sr_filter got %h want 13", filter_ctl_o); end
    checks++; if (power_ctl_o !== 8'h00) begin errors++; $display("FAIL sr_power got %h want 00", power_ctl_o); end
    checks++; if (wr_addr_o !== 6'h1F) begin errors++; $display("FAIL sr_wr_addr got %h want 1f", wr_addr_o); end
    s0 = stb_cnt;
    cs_low();
    spi_xfer(8'h0A, 8, rx);
    spi_xfer(8'h2D, 8, rx);
    spi_xfer(8'hFF, 5, rx);
    cs_high();
    checks++; if (power_ctl_o !== 8'h00) begin errors++; $display("FAIL trunc_power got %h want 00", power_ctl_o); end
    checks++; if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL trunc_stb got %0d want 0", stb_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    spi_write(6'h2D, 8'h07);
    checks++; if (power_ctl_o !== 8'h07) begin errors++; $display("FAIL rm_power_pre got %h want 07", power_ctl_o); end
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h00, 8, rx);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (miso_o !== 1'b0) begin errors++; $display("FAIL rm_miso got %b want 0", miso_o); end
    checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL rm_oe got %b want 0", miso_oe_o); end
    checks++; if (power_ctl_o !== 8'h00) begin errors++; $display("FAIL rm_power got %h want 00", power_ctl_o); end
    checks++; if (filter_ctl_o !== 8'h13) begin errors++; $display("FAIL rm_filter got %h want 13", filter_ctl_o); end
    checks++; if (wr_addr_o !== 6'h00) begin errors++; $display("FAIL rm_wr_addr got %h want 00", wr_addr_o); end
    spi_xfer(8'h0B, 8, rx);
    checks++; if (rx !== 8'h00) begin errors++; $display("FAIL rm_idle_miso got %h want 00", rx); end
    checks++; if (miso_oe_o !== 1'b0) begin errors++; $display("FAIL rm_idle_oe got %b want 0", miso_oe_o); end
    cs_high();
    cs_low();
    spi_xfer(8'h0B, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 8, rx);
    cs_high();
    checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL rm_reread got %h want ad", rx); end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_write_power();
    test_snapshot();
    test_samples();
    test_wrap();
    test_bad_cmd();
    test_soft_reset();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
